pool_stage: RTL and testbench

//  Pooling stage directly downstream of the normalization block.
//  - Consumes 8 lane streams. Lane i carries column i of the normalized matmul output.
//  - Lanes arrive skewed: lane i lags lane 0 by i cycles.
//  - Deskews the lanes, then applies PWxPW max or average pooling (PW = 1/2/4): lanes horizontally, consecutive rows vertically.
//  - Emits pooled rows, all lanes aligned, to the activation stage.

---
 rtl/pool_pkg.sv | 21 ++
 rtl/pool_if.sv | 24 ++
 rtl/pool_deskew.sv | 22 ++
 rtl/pool_stage.sv | 104 ++++++++++
 tb/tb_pool_stage.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pool_pkg.sv
// pool_pkg: shared widths, pooling encodings and helpers for the norm/pool datapath
package pool_pkg;
   localparam int DWIDTH       = 8;
   localparam int NUM_LANES    = 8;
   localparam int MASK_WIDTH   = 8;
   localparam int ACC_WIDTH    = DWIDTH + 4;
   localparam int DEF_MAT_ROWS = 8;
   localparam logic [2:0] PW_1 = 3'd1;
   localparam logic [2:0] PW_2 = 3'd2;
   localparam logic [2:0] PW_4 = 3'd4;
   typedef enum logic {POOL_MAX = 1'b0, POOL_AVG = 1'b1} pool_sel_e;
   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} pool_state_e;
   // Unsupported window codes fall back to a 1x1 window.
   function automatic logic [2:0] pw_decode(input logic [2:0] w);
      return (w == PW_2 || w == PW_4) ? w : PW_1;
   endfunction
   // log2 of a decoded window width.
   function automatic logic [1:0] pw_shift(input logic [2:0] pw);
      return (pw == PW_4) ? 2'd2 : (pw == PW_2) ? 2'd1 : 2'd0;
   endfunction
endpackage

// File: rtl/pool_if.sv
// pool_if: configuration, skewed lane input and aligned pooled output of the pool stage
//  enable_pool, pool_select, pool_window, validity_mask : configuration (master -> slave)
//  in_data_available, inp_data[lane]                    : skewed input rows (master -> slave)
//  out_data[lane], out_data_available, done_pool        : pooled rows (slave -> master)
interface pool_if;
   import pool_pkg::*;
   logic                              enable_pool;
   logic                              pool_select;
   logic [2:0]                        pool_window;
   logic [MASK_WIDTH-1:0]             validity_mask;
   logic                              in_data_available;
   logic [NUM_LANES-1:0][DWIDTH-1:0]  inp_data;
   logic [NUM_LANES-1:0][DWIDTH-1:0]  out_data;
   logic                              out_data_available;
   logic                              done_pool;
   modport master (
      output enable_pool, pool_select, pool_window, validity_mask, in_data_available, inp_data,
      input  out_data, out_data_available, done_pool
   );
   modport slave (
      input  enable_pool, pool_select, pool_window, validity_mask, in_data_available, inp_data,
      output out_data, out_data_available, done_pool
   );
endinterface

// File: rtl/pool_deskew.sv
// pool_deskew: fixed-depth delay line used to realign one skewed lane
//  clk, reset : clock, synchronous active-high reset (clears the line)
//  d_i        : lane input
//  q_o        : lane input delayed by DEPTH cycles
module pool_deskew #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] pipe_q [DEPTH];
   always_ff @(posedge clk)
      if (reset) pipe_q <= '{default: '0};
      else begin
         pipe_q[0] <= d_i;
         for (int k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
      end
   assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/pool_stage.sv
// pool_stage: deskews 8 normalized lanes and applies PWxPW max/average pooling per tile
//  clk, reset : clock, synchronous active-high reset
//  pool_io    : pool_if.slave -- configuration, skewed lane rows in, aligned pooled rows out,
//               out_data_available pulse per pooled row, sticky done_pool at tile end
module pool_stage
   import pool_pkg::*;
#(
   parameter int MAT_ROWS = DEF_MAT_ROWS
) (
   input  logic  clk,
   input  logic  reset,
   pool_if.slave pool_io
);
   localparam int TW = $clog2(MAT_ROWS + 1);
   typedef logic signed [ACC_WIDTH-1:0] acc_t;
   logic                             clr, row_vld, first, last, accept, close;
   logic [DWIDTH-1:0]                row_data [NUM_LANES];
   pool_state_e                      state_q, state_d;
   acc_t                             acc_q [NUM_LANES];
   acc_t                             acc_d [NUM_LANES];
   acc_t                             lane_v [NUM_LANES];
   acc_t                             row_sum [NUM_LANES];
   acc_t                             row_max [NUM_LANES];
   acc_t                             win_v [NUM_LANES];
   logic [NUM_LANES-1:0][DWIDTH-1:0] out_q, out_d;
   logic                             avail_q, avail_d, done_q, done_d;
   logic [1:0]                       win_row_q, win_row_d, sh;
   logic [TW-1:0]                    tile_rows_q, tile_rows_d;
   logic [2:0]                       pw_q, pw_d, pw_cur;
   pool_sel_e                        sel_q, sel_d, sel_cur;
   // Bypass keeps the whole stage, deskew lines included, in reset.
   assign clr = reset | ~pool_io.enable_pool;
   // Lane i lags lane 0 by i cycles, so it needs NUM_LANES-i stages to line up.
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      pool_deskew #(.WIDTH(DWIDTH), .DEPTH(NUM_LANES - i)) u_dsk (
         .clk(clk), .reset(clr), .d_i(pool_io.inp_data[i]), .q_o(row_data[i])
      );
   end
   pool_deskew #(.WIDTH(1), .DEPTH(NUM_LANES)) u_vld (
      .clk(clk), .reset(clr), .d_i(pool_io.in_data_available), .q_o(row_vld)
   );
   always_comb begin
      // Window width and mode are taken live on a window's first row and held after.
      first       = (win_row_q == 2'd0);
      pw_cur      = first ? pw_decode(pool_io.pool_window) : pw_q;
      sel_cur     = first ? pool_sel_e'(pool_io.pool_select) : sel_q;
      sh          = pw_shift(pw_cur);
      accept      = row_vld && state_q != S_DONE;
      last        = (tile_rows_q == TW'(MAT_ROWS - 1));
      close       = accept && ({1'b0, win_row_q} == pw_cur - 3'd1 || last);
      for (int i = 0; i < NUM_LANES; i++)
         lane_v[i] = pool_io.validity_mask[i] ? acc_t'($signed(row_data[i])) : '0;
      // Group j collects lanes whose index >> log2(PW) equals j; unused groups stay 0.
      for (int j = 0; j < NUM_LANES; j++) begin
         row_sum[j] = '0;
         row_max[j] = '0;
         for (int i = 0; i < NUM_LANES; i++)
            if ((3'(i) >> sh) == 3'(j)) begin
               row_sum[j] = row_sum[j] + lane_v[i];
               row_max[j] = ((3'(i) & (pw_cur - 3'd1)) == 3'd0 || lane_v[i] > row_max[j]) ? lane_v[i] : row_max[j];
            end
      end
      for (int j = 0; j < NUM_LANES; j++) begin
         win_v[j] = (sel_cur == POOL_AVG) ? acc_q[j] + row_sum[j]
                  : (first || row_max[j] > acc_q[j]) ? row_max[j] : acc_q[j];
         acc_d[j] = accept ? (close ? '0 : win_v[j]) : acc_q[j];
         // Average always divides by the full PW*PW, even for a truncated last window.
         out_d[j] = !close ? out_q[j]
                  : (sel_cur == POOL_AVG) ? DWIDTH'(win_v[j] >>> {sh, 1'b0}) : DWIDTH'(win_v[j]);
      end
      win_row_d   = accept ? (close ? 2'd0 : win_row_q + 2'd1) : win_row_q;
      tile_rows_d = accept ? tile_rows_q + TW'(1) : tile_rows_q;
      pw_d        = (accept && first) ? pw_cur : pw_q;
      sel_d       = (accept && first) ? sel_cur : sel_q;
      avail_d     = close;
      done_d      = done_q | (close & last);
      state_d     = accept ? (last ? S_DONE : S_ACCUM) : state_q;
   end
   always_ff @(posedge clk)
      if (clr) begin
         state_q     <= S_IDLE;
         acc_q       <= '{default: '0};
         out_q       <= '0;
         avail_q     <= 1'b0;
         done_q      <= 1'b0;
         win_row_q   <= '0;
         tile_rows_q <= '0;
         pw_q        <= PW_1;
         sel_q       <= POOL_MAX;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         out_q       <= out_d;
         avail_q     <= avail_d;
         done_q      <= done_d;
         win_row_q   <= win_row_d;
         tile_rows_q <= tile_rows_d;
         pw_q        <= pw_d;
         sel_q       <= sel_d;
      end
   assign pool_io.out_data           = pool_io.enable_pool ? out_q : pool_io.inp_data;
   assign pool_io.out_data_available = pool_io.enable_pool ? avail_q : pool_io.in_data_available;
   assign pool_io.done_pool          = pool_io.enable_pool & done_q;
endmodule

// File: tb/tb_pool_stage.sv
// tb_pool_stage: directed and randomized tiles checked against a window-level pooling model
module tb_pool_stage;
   import pool_pkg::*;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   pool_if bus ();
   pool_stage dut (.clk(clk), .reset(reset), .pool_io(bus));
   int tests = 0;
   int fails = 0;
   int rows_v [8][8];
   int start_c [8];
   int mask, sel, pw_a, pw_b, sw_c;
   logic [63:0] exp_data [8];
   int exp_cyc [8];
   int n_win, done_cyc;
   logic [63:0] byp_v;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask
   function automatic int pwdec(input int w);
      return (w == 2 || w == 4) ? w : 1;
   endfunction
   // Walk the tile window by window: each window takes PW rows (fewer at tile end),
   // PW being the window code live when its first row is realigned (input cycle + 8).
   task automatic build_model(input int nrows);
      int r, pw, n, v, acc, d, q;
      logic [63:0] pk;
      r = 0;
      n_win = 0;
      done_cyc = 1 << 30;
      while (r < nrows) begin
         pw = pwdec((start_c[r] + 8 < sw_c) ? pw_a : pw_b);
         n = (8 - r < pw) ? 8 - r : pw;
         if (r + n > nrows) break;
         pk = '0;
         for (int j = 0; j < 8 / pw; j++) begin
            acc = (sel != 0) ? 0 : -1000;
            for (int rr = r; rr < r + n; rr++)
               for (int k = 0; k < pw; k++) begin
                  v = mask[j*pw+k] ? rows_v[rr][j*pw+k] : 0;
                  acc = (sel != 0) ? acc + v : ((v > acc) ? v : acc);
               end
            if (sel != 0) begin
               d = pw * pw;
               q = acc / d;
               if (acc % d != 0 && acc < 0) q = q - 1;
               acc = q;
            end
            pk[j*8 +: 8] = 8'(acc);
         end
         exp_data[n_win] = pk;
         exp_cyc[n_win] = start_c[r+n-1] + 9;
         n_win++;
         if (r + n == 8) done_cyc = start_c[r+n-1] + 9;
         r += n;
      end
   endtask
   task automatic drive(input int c, input int nrows);
      bus.in_data_available = 1'b0;
      for (int i = 0; i < 8; i++) bus.inp_data[i] = 8'($urandom);
      for (int r = 0; r < nrows; r++) begin
         if (start_c[r] == c) bus.in_data_available = 1'b1;
         for (int i = 0; i < 8; i++)
            if (start_c[r] + i == c) bus.inp_data[i] = 8'(rows_v[r][i]);
      end
      bus.pool_window = 3'((c < sw_c) ? pw_a : pw_b);
   endtask
   task automatic tile(input int nrows, input bit do_rst);
      int wi;
      bit pulse;
      bus.pool_select = 1'(sel);
      bus.validity_mask = 8'(mask);
      if (do_rst) begin
         reset = 1'b1;
         bus.in_data_available = 1'b0;
         repeat (2) @(posedge clk);
         #1 reset = 1'b0;
      end
      build_model(nrows);
      wi = 0;
      for (int c = 0; c <= start_c[nrows-1] + 14; c++) begin
         @(posedge clk);
         #1 drive(c, nrows);
         @(negedge clk);
         pulse = (wi < n_win && exp_cyc[wi] == c);
         chk("avail", 64'(bus.out_data_available), 64'(pulse));
         chk("done", 64'(bus.done_pool), 64'(c >= done_cyc));
         if (pulse) begin
            chk("data", bus.out_data, exp_data[wi]);
            wi++;
         end
      end
      if (n_win > 0) chk("hold", bus.out_data, exp_data[n_win-1]);
   endtask
   task automatic seq_starts(input int gap_after, input int gap_len);
      for (int r = 0; r < 8; r++) start_c[r] = r + ((r > gap_after) ? gap_len : 0);
   endtask
   task automatic rand_rows(input int max_gap);
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 8; i++) rows_v[r][i] = int'($urandom_range(255)) - 128;
         start_c[r] = (r == 0) ? 0 : start_c[r-1] + 1 + int'($urandom_range(max_gap));
      end
   endtask
   initial begin
      reset = 1'b1;
      bus.enable_pool = 1'b0;
      bus.pool_select = 1'b0;
      bus.pool_window = 3'd1;
      bus.validity_mask = 8'hFF;
      bus.in_data_available = 1'b0;
      bus.inp_data = '0;
      #1;
      bus.inp_data[3] = 8'h5A;
      bus.in_data_available = 1'b1;
      #1;
      chk("byp_data3", 64'(bus.out_data[3]), 64'h5A);
      chk("byp_avail", 64'(bus.out_data_available), 64'd1);
      chk("byp_done", 64'(bus.done_pool), 64'd0);
      bus.enable_pool = 1'b1;
      bus.in_data_available = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_data", bus.out_data, 64'd0);
      chk("rst_avail", 64'(bus.out_data_available), 64'd0);
      chk("rst_done", 64'(bus.done_pool), 64'd0);
      // PW=1 max, lane i of row r = r*8+i
      sel = 0; mask = 255; pw_a = 1; pw_b = 1; sw_c = 0;
      seq_starts(8, 0);
      for (int r = 0; r < 8; r++) for (int i = 0; i < 8; i++) rows_v[r][i] = r * 8 + i;
      tile(8, 1);
      // PW=2 max on alternating {-5,3}/{7,-128}
      pw_a = 2; pw_b = 2;
      for (int r = 0; r < 8; r++) for (int i = 0; i < 8; i++)
         rows_v[r][i] = (i == 0) ? ((r % 2 == 0) ? -5 : 7) : (i == 1) ? ((r % 2 == 0) ? 3 : -128) : 0;
      tile(8, 1);
      // PW=4 average, lane i = i
      sel = 1; pw_a = 4; pw_b = 4;
      for (int r = 0; r < 8; r++) for (int i = 0; i < 8; i++) rows_v[r][i] = i;
      tile(8, 1);
      // PW=2 average floor, then with lane 0 masked
      pw_a = 2; pw_b = 2;
      for (int r = 0; r < 8; r++) for (int i = 0; i < 8; i++)
         rows_v[r][i] = (i == 0) ? ((r % 2 == 0) ? -1 : -2) : (i == 1) ? -2 : 0;
      tile(8, 1);
      mask = 8'hFE;
      tile(8, 1);
      // 3-cycle gap inside the first window
      sel = 0; mask = 255;
      rand_rows(0);
      seq_starts(0, 3);
      tile(8, 1);
      // window code switches mid-window, leaving a truncated last window
      sel = 1; pw_a = 2; pw_b = 4;
      rand_rows(0);
      sw_c = start_c[1] + 8;
      tile(8, 1);
      // reset after one row of a window, then a clean tile
      sel = 0; pw_a = 2; pw_b = 2; sw_c = 0;
      for (int i = 0; i < 8; i++) rows_v[0][i] = 127;
      start_c[0] = 0;
      tile(1, 1);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_data", bus.out_data, 64'd0);
      chk("midrst_avail", 64'(bus.out_data_available), 64'd0);
      rand_rows(1);
      tile(8, 0);
      // enable dropped after one row: bypass for a cycle, then a clean tile
      for (int i = 0; i < 8; i++) rows_v[0][i] = 127;
      start_c[0] = 0;
      tile(1, 1);
      byp_v = {$urandom, $urandom};
      bus.enable_pool = 1'b0;
      bus.inp_data = byp_v;
      bus.in_data_available = 1'b1;
      #1;
      chk("drop_data", bus.out_data, byp_v);
      chk("drop_avail", 64'(bus.out_data_available), 64'd1);
      chk("drop_done", 64'(bus.done_pool), 64'd0);
      @(posedge clk);
      #1;
      bus.enable_pool = 1'b1;
      bus.in_data_available = 1'b0;
      rand_rows(1);
      tile(8, 0);
      // randomized tiles: any window code, mode, mask, gaps and mid-tile code switches
      for (int t = 0; t < 8; t++) begin
         sel = int'($urandom_range(1));
         mask = int'($urandom_range(255));
         pw_a = int'($urandom_range(7));
         pw_b = (t % 2 == 0) ? pw_a : int'($urandom_range(7));
         rand_rows(2);
         sw_c = int'($urandom_range(20));
         tile(8, 1);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
